decode_stage: RTL and testbench

//  Instruction-decode stage between instruction fetch and RegisterFile in tinyCPU (RV32I).

---
 rtl/decode_if.sv | 36 +++
 rtl/decode_stage.sv | 150 +++++++++++++++
 tb/tb_decode_stage.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_if.sv
// Signal bundle around the decode stage: fetch handshake, decoded bundle to execute,
// RegisterFile read addresses and the writeback notification.
interface decode_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [DATA_W-1:0] in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] out_imm;
  logic [4:0]        out_rd;
  logic              out_reg_write;
  logic              out_illegal;
  logic [4:0]        rf_rs1;
  logic [4:0]        rf_rs2;
  logic              wb_valid;
  logic [4:0]        wb_rd;

  // master: the surrounding pipeline (fetch, execute, writeback)
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready, wb_valid, wb_rd,
    input  in_ready, out_valid, out_pc, out_imm, out_rd, out_reg_write, out_illegal,
           rf_rs1, rf_rs2
  );

  // slave: the decode stage itself
  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready, wb_valid, wb_rd,
    output in_ready, out_valid, out_pc, out_imm, out_rd, out_reg_write, out_illegal,
           rf_rs1, rf_rs2
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry output register, immediate/register extraction and a
// 32-entry pending-writeback scoreboard that stalls issue on RAW/WAW hazards.
module decode_stage #(
  parameter int DATA_W = 32,
  parameter bit SB_EN  = 1'b1
) (
  input logic     clk,
  input logic     reset,
  decode_if.slave bus
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_J     = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [31:0]       instr;
  logic              is_r, is_i, is_s, is_b, is_j, is_u, is_illegal;
  logic              uses_rs1, uses_rs2, writes_rd;
  logic [4:0]        dec_rs1, dec_rs2, dec_rd;
  logic [31:0]       imm32;
  logic [DATA_W-1:0] dec_imm;

  logic              valid_reg;
  logic [DATA_W-1:0] pc_reg;
  logic [DATA_W-1:0] imm_reg;
  logic [4:0]        rd_reg;
  logic              reg_write_reg;
  logic              illegal_reg;
  logic [4:0]        rs1_reg, rs2_reg;
  logic [31:0]       sb_reg;
  logic [31:0]       sb_next;

  logic hazard;
  logic in_fire;
  logic issue;
  logic unused_funct3;

  assign instr         = bus.in_instr[31:0];
  assign unused_funct3 = ^instr[14:12];

  always_comb begin
    is_r       = 1'b0;
    is_i       = 1'b0;
    is_s       = 1'b0;
    is_b       = 1'b0;
    is_j       = 1'b0;
    is_u       = 1'b0;
    is_illegal = 1'b0;
    case (instr[6:0])
      OP_R:                    is_r = 1'b1;
      OP_I, OP_LOAD, OP_JALR:  is_i = 1'b1;
      OP_S:                    is_s = 1'b1;
      OP_B:                    is_b = 1'b1;
      OP_J:                    is_j = 1'b1;
      OP_LUI, OP_AUIPC:        is_u = 1'b1;
      default:                 is_illegal = 1'b1;
    endcase
  end

  assign uses_rs1  = is_r | is_i | is_s | is_b;
  assign uses_rs2  = is_r | is_s | is_b;
  assign writes_rd = (is_r | is_i | is_j | is_u) & (instr[11:7] != 5'd0);
  // Unused fields are forced to x0 so they can never match a pending scoreboard entry.
  assign dec_rs1   = uses_rs1  ? instr[19:15] : 5'd0;
  assign dec_rs2   = uses_rs2  ? instr[24:20] : 5'd0;
  assign dec_rd    = writes_rd ? instr[11:7]  : 5'd0;

  always_comb begin
    imm32 = 32'd0;
    if (is_i)      imm32 = {{20{instr[31]}}, instr[31:20]};
    else if (is_s) imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    else if (is_b) imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    else if (is_j) imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    else if (is_u) imm32 = {instr[31:12], 12'b0};
  end

  assign dec_imm = DATA_W'($signed(imm32));

  assign hazard  = SB_EN && bus.in_valid &&
                   ((uses_rs1 && sb_reg[dec_rs1]) ||
                    (uses_rs2 && sb_reg[dec_rs2]) ||
                    (writes_rd && sb_reg[dec_rd]));

  assign bus.in_ready = (!valid_reg || bus.out_ready) && !hazard && !bus.flush;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign issue        = valid_reg && bus.out_ready && reg_write_reg;

  // A set and a clear of the same register on one edge leave it pending: the new
  // writer has not yet written back.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_sb
      if (gi == 0) begin : g_x0
        assign sb_next[gi] = 1'b0;
      end else begin : g_reg
        logic set_hit, clr_hit;
        assign set_hit     = issue && (rd_reg == 5'(gi));
        assign clr_hit     = bus.wb_valid && (bus.wb_rd == 5'(gi));
        assign sb_next[gi] = set_hit || (sb_reg[gi] && !clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg     <= 1'b0;
      pc_reg        <= '0;
      imm_reg       <= '0;
      rd_reg        <= 5'd0;
      reg_write_reg <= 1'b0;
      illegal_reg   <= 1'b0;
      rs1_reg       <= 5'd0;
      rs2_reg       <= 5'd0;
      sb_reg        <= 32'd0;
    end else begin
      sb_reg <= sb_next;
      if (bus.flush) begin
        valid_reg <= 1'b0;
      end else if (in_fire) begin
        valid_reg     <= 1'b1;
        pc_reg        <= bus.in_pc;
        imm_reg       <= dec_imm;
        rd_reg        <= dec_rd;
        reg_write_reg <= writes_rd;
        illegal_reg   <= is_illegal;
        rs1_reg       <= dec_rs1;
        rs2_reg       <= dec_rs2;
      end else if (bus.out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_valid     = valid_reg;
  assign bus.out_pc        = pc_reg;
  assign bus.out_imm       = imm_reg;
  assign bus.out_rd        = rd_reg;
  assign bus.out_reg_write = reg_write_reg;
  assign bus.out_illegal   = illegal_reg;
  // RegisterFile latches its address on the accept edge, so present the new fields then.
  assign bus.rf_rs1        = in_fire ? dec_rs1 : rs1_reg;
  assign bus.rf_rs2        = in_fire ? dec_rs2 : rs2_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed hazard/stall/flush sequences with a queue of expected
// bundles pushed on accept and compared when execute consumes them.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } bundle_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  bundle_t exp_q[$];

  always #5 clk = ~clk;

  decode_if #(.DATA_W(32)) bus ();

  decode_stage #(.DATA_W(32), .SB_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic bundle_t model(input logic [31:0] i, input logic [31:0] pc);
    bundle_t b;
    b    = '0;
    b.pc = pc;
    case (i[6:0])
      7'h33: begin b.rs1 = i[19:15]; b.rs2 = i[24:20]; b.rd = i[11:7]; end
      7'h13, 7'h03, 7'h67: begin
        b.rs1 = i[19:15]; b.rd = i[11:7];
        b.imm = {{20{i[31]}}, i[31:20]};
      end
      7'h23: begin
        b.rs1 = i[19:15]; b.rs2 = i[24:20];
        b.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      7'h63: begin
        b.rs1 = i[19:15]; b.rs2 = i[24:20];
        b.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      7'h6F: begin b.rd = i[11:7]; b.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; end
      7'h37, 7'h17: begin b.rd = i[11:7]; b.imm = {i[31:12], 12'b0}; end
      default: b.ill = 1'b1;
    endcase
    b.rw = (b.rd != 5'd0);
    return b;
  endfunction

  // Monitor: compare on consume, push the model's bundle on accept.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          bundle_t e;
          e = exp_q.pop_front();
          check("out_pc",        bus.out_pc,                 e.pc);
          check("out_imm",       bus.out_imm,                e.imm);
          check("out_rd",        32'(bus.out_rd),            32'(e.rd));
          check("out_reg_write", 32'(bus.out_reg_write),     32'(e.rw));
          check("out_illegal",   32'(bus.out_illegal),       32'(e.ill));
          $display("consume pc=%h imm=%h rd=%0d rw=%0d ill=%0d", bus.out_pc, bus.out_imm,
                   bus.out_rd, bus.out_reg_write, bus.out_illegal);
        end
      end else if (bus.out_valid && bus.flush && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        $display("flush killed held bundle");
      end
      if (bus.in_valid && bus.in_ready) begin
        bundle_t n;
        n = model(bus.in_instr, bus.in_pc);
        check("rf_rs1_accept", 32'(bus.rf_rs1), 32'(n.rs1));
        check("rf_rs2_accept", 32'(bus.rf_rs2), 32'(n.rs2));
        exp_q.push_back(n);
        $display("accept pc=%h instr=%h", bus.in_pc, bus.in_instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  initial begin
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = 5'd0;
    drive(1'b0, 32'd0, 32'd0);
    step(); step();
    reset = 1'b0;

    // 1: reset state, then addi x1,x0,5
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_pc",    bus.out_pc,         32'd0);
    check("rst_out_imm",   bus.out_imm,        32'd0);
    check("rst_out_rd",    32'(bus.out_rd),    32'd0);
    check("rst_rw",        32'(bus.out_reg_write), 32'd0);
    check("rst_ill",       32'(bus.out_illegal),   32'd0);
    check("rst_rf_rs1",    32'(bus.rf_rs1),    32'd0);
    step();
    drive(1'b1, 32'h00500093, 32'h100);
    @(negedge clk);
    check("addi_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    drive(1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("addi_valid", 32'(bus.out_valid), 32'd1);
    check("addi_rd",    32'(bus.out_rd),    32'd1);
    check("addi_imm",   bus.out_imm,        32'd5);
    check("addi_rw",    32'(bus.out_reg_write), 32'd1);
    check("addi_rs1",   32'(bus.rf_rs1),    32'd0);
    step();

    // 2: issue addi x1, then add x2,x1,x1 stalls until x1 writes back
    bus.out_ready = 1'b1;
    @(negedge clk);
    step();
    drive(1'b1, 32'h00108133, 32'h104);
    @(negedge clk);
    check("raw_stall0", 32'(bus.in_ready), 32'd0);
    step();
    @(negedge clk);
    check("raw_stall1", 32'(bus.in_ready), 32'd0);
    step();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd1;
    @(negedge clk);
    check("no_bypass", 32'(bus.in_ready), 32'd0);
    step();
    bus.wb_valid = 1'b0;
    @(negedge clk);
    check("raw_release", 32'(bus.in_ready), 32'd1);
    check("add_rs1",     32'(bus.rf_rs1),   32'd1);
    check("add_rs2",     32'(bus.rf_rs2),   32'd1);
    step();
    drive(1'b0, 32'd0, 32'd0);
    @(negedge clk);
    step();

    // 3: output stall holds everything while the next instruction waits
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00728193, 32'h108);
    @(negedge clk);
    step();
    drive(1'b1, 32'h00A00213, 32'h10C);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_valid",    32'(bus.out_valid), 32'd1);
      check("hold_pc",       bus.out_pc,         32'h108);
      check("hold_imm",      bus.out_imm,        32'd7);
      check("hold_rs1",      32'(bus.rf_rs1),    32'd5);
      check("hold_in_ready", 32'(bus.in_ready),  32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("unstall_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    drive(1'b0, 32'd0, 32'd0);
    @(negedge clk);
    step();

    // 4: branch immediate, then flush blocks input and kills the slot
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hFE000EE3, 32'h110);
    @(negedge clk);
    step();
    drive(1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("beq_imm", bus.out_imm,                32'hFFFFFFFC);
    check("beq_rw",  32'(bus.out_reg_write),     32'd0);
    step();
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h123452B7, 32'h114);
    @(negedge clk);
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("flushed_valid", 32'(bus.out_valid), 32'd0);
    step();

    // 5: lui immediate, illegal opcode leaves scoreboard alone
    drive(1'b1, 32'h0000037F, 32'h118);
    @(negedge clk);
    check("lui_imm", bus.out_imm,         32'h12345000);
    check("lui_rd",  32'(bus.out_rd),     32'd5);
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    step();
    drive(1'b0, 32'd0, 32'd0);
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("ill_flag", 32'(bus.out_illegal),   32'd1);
    check("ill_rw",   32'(bus.out_reg_write), 32'd0);
    check("ill_rd",   32'(bus.out_rd),        32'd0);
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    step();
    drive(1'b1, 32'h000303B3, 32'h11C);
    @(negedge clk);
    check("ill_no_sb", 32'(bus.in_ready), 32'd1);
    step();
    drive(1'b0, 32'd0, 32'd0);
    @(negedge clk);
    step();

    // 6: issue to x3 on the same edge as its writeback keeps it pending; reset clears
    bus.out_ready = 1'b0;
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 5'd3;
    @(negedge clk);
    step();
    bus.wb_valid = 1'b0;
    drive(1'b1, 32'h00100193, 32'h120);
    @(negedge clk);
    step();
    drive(1'b0, 32'd0, 32'd0);
    bus.out_ready = 1'b1;
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 5'd3;
    @(negedge clk);
    step();
    bus.wb_valid = 1'b0;
    drive(1'b1, 32'h00018433, 32'h124);
    @(negedge clk);
    check("sb_set_wins", 32'(bus.in_ready), 32'd0);
    step();
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst2_valid",    32'(bus.out_valid), 32'd0);
    check("rst2_pc",       bus.out_pc,         32'd0);
    check("rst2_in_ready", 32'(bus.in_ready),  32'd1);
    step();
    drive(1'b0, 32'd0, 32'd0);
    @(negedge clk);
    step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
